// File: rtl/present_pkg.sv
// Shared PRESENT constants, round primitives and FSM state type for the iterative core.
// Vectors use MSB-first numbering ([0:N-1], bit 0 is the MSB), matching the cipher description.
package present_pkg;

  localparam int NUM_STEPS = 32;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_e;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [0:63] sbox_layer(input logic [0:63] s);
    logic [0:63] r;
    r = '0;
    for (int n = 0; n < 16; n++) begin
      r[4*n +: 4] = sbox4(s[4*n +: 4]);
    end
    return r;
  endfunction

  // Bit j lands on 16*j mod 63; the last bit is a fixed point of the permutation.
  function automatic logic [0:63] p_layer(input logic [0:63] s);
    logic [0:63] r;
    r = '0;
    for (int j = 0; j < 63; j++) begin
      r[(16*j) % 63] = s[j];
    end
    r[63] = s[63];
    return r;
  endfunction

  function automatic logic [0:79] key_update80(input logic [0:79] k, input logic [0:4] rc);
    logic [0:79] r;
    r = {k[61:79], k[0:60]};
    r[0:3] = sbox4(r[0:3]);
    r[60:64] = r[60:64] ^ rc;
    return r;
  endfunction

  function automatic logic [0:127] key_update128(input logic [0:127] k, input logic [0:4] rc);
    logic [0:127] r;
    r = {k[61:127], k[0:60]};
    r[0:3] = sbox4(r[0:3]);
    r[4:7] = sbox4(r[4:7]);
    r[61:65] = r[61:65] ^ rc;
    return r;
  endfunction

endpackage

// File: rtl/present_step.sv
// One combinational PRESENT round step: key mixing, then S-box/pLayer/key schedule
// unless this is the final whitening step.
module present_step
  import present_pkg::*;
#(
  parameter int KEY_W = 80
) (
  input  logic [0:63]      state_i,
  input  logic [0:KEY_W-1] key_i,
  input  logic [5:0]       step_i,
  input  logic             last_i,
  output logic [0:63]      state_o,
  output logic [0:KEY_W-1] key_o
);

  logic [0:63]      mixed;
  logic [0:KEY_W-1] key_upd;
  logic             step_unused;

  assign mixed       = state_i ^ key_i[0:63];
  // Only the low five bits of the step number enter the key schedule.
  assign step_unused = step_i[5];

  if (KEY_W == 128) begin : g_k128
    assign key_upd = key_update128(key_i, step_i[4:0]);
  end else begin : g_k80
    assign key_upd = key_update80(key_i, step_i[4:0]);
  end

  assign state_o = last_i ? mixed : p_layer(sbox_layer(mixed));
  assign key_o   = last_i ? key_i : key_upd;

endmodule

// File: rtl/present_iter_core.sv
// Iterative PRESENT encryption engine: UNROLL chained round steps per clock, with
// valid/ready handshakes on the plaintext and ciphertext sides.
module present_iter_core
  import present_pkg::*;
#(
  parameter int KEY_W  = 80,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:63]      in_pt,
  input  logic [0:KEY_W-1] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:63]      out_ct,
  output logic             busy
);

  if (!(KEY_W == 80 || KEY_W == 128)) begin : g_bad_key_w
    $error("present_iter_core: KEY_W must be 80 or 128");
  end
  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 ||
        UNROLL == 16 || UNROLL == 32)) begin : g_bad_unroll
    $error("present_iter_core: UNROLL must be 1, 2, 4, 8, 16 or 32");
  end

  localparam logic [5:0] STEP_INC   = 6'(UNROLL);
  localparam logic [5:0] LAST_BASE  = 6'(NUM_STEPS + 1 - UNROLL);
  localparam logic [5:0] FINAL_STEP = 6'(NUM_STEPS);

  fsm_e             fsm_q;
  logic [5:0]       step_q;
  logic [0:63]      state_q;
  logic [0:63]      state_d;
  logic [0:63]      ct_q;
  logic [0:KEY_W-1] key_q;
  logic [0:KEY_W-1] key_d;
  logic             out_valid_q;
  logic             busy_q;
  logic             in_ready_q;

  logic [0:63]      state_chain [UNROLL+1];
  logic [0:KEY_W-1] key_chain   [UNROLL+1];

  assign state_chain[0] = state_q;
  assign key_chain[0]   = key_q;

  // Steps step_q .. step_q+UNROLL-1 run back to back within one cycle.
  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    logic [5:0] step_num;
    assign step_num = step_q + 6'(g);

    present_step #(.KEY_W(KEY_W)) u_step (
      .state_i (state_chain[g]),
      .key_i   (key_chain[g]),
      .step_i  (step_num),
      .last_i  (step_num == FINAL_STEP),
      .state_o (state_chain[g+1]),
      .key_o   (key_chain[g+1])
    );
  end

  assign state_d = state_chain[UNROLL];
  assign key_d   = key_chain[UNROLL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      step_q      <= '0;
      state_q     <= '0;
      key_q       <= '0;
      ct_q        <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= in_pt;
            key_q      <= in_key;
            step_q     <= 6'd1;
            fsm_q      <= RUN;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
          end
        end
        RUN: begin
          state_q <= state_d;
          key_q   <= key_d;
          if (step_q == LAST_BASE) begin
            ct_q        <= state_d;
            out_valid_q <= 1'b1;
            fsm_q       <= DONE;
          end else begin
            step_q <= step_q + STEP_INC;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm_q       <= IDLE;
          end
        end
        default: begin
          fsm_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ct    = ct_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_present_iter_core.sv
// Self-checking bench for present_iter_core: known-answer vectors, unroll latency,
// backpressure, asynchronous abort and a randomized sweep against a reference model.
module tb_present_iter_core;

  localparam int NJOBS = 1000;

  localparam logic [3:0] SB [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [0:63] in_pt;
  logic [0:79] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [0:63] out_ct;
  logic        busy;

  logic         v128;
  logic         r128;
  logic [0:63]  pt128;
  logic [0:127] key128;
  logic         ir128 [6];
  logic         ov128 [6];
  logic [0:63]  ct128 [6];
  logic         bz128 [6];

  int checks;
  int errors;

  present_iter_core #(.KEY_W(80), .UNROLL(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pt     (in_pt),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ct    (out_ct),
    .busy      (busy)
  );

  for (genvar g = 0; g < 6; g++) begin : g_bank
    present_iter_core #(.KEY_W(128), .UNROLL(1 << g)) dut128 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v128),
      .in_ready  (ir128[g]),
      .in_pt     (pt128),
      .in_key    (key128),
      .out_valid (ov128[g]),
      .out_ready (r128),
      .out_ct    (ct128[g]),
      .busy      (bz128[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Textbook PRESENT with LSB-first numbering: 31 full rounds plus final whitening.
  function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [127:0] key,
                                          input bit is128);
    logic [63:0]  s;
    logic [63:0]  t;
    logic [127:0] k;
    logic [79:0]  k80;
    s   = pt;
    k   = key;
    k80 = key[79:0];
    for (int r = 1; r <= 32; r++) begin
      s = s ^ (is128 ? k[127:64] : k80[79:16]);
      if (r == 32) break;
      for (int n = 0; n < 16; n++) s[4*n +: 4] = SB[s[4*n +: 4]];
      t = '0;
      for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : (b * 16) % 63] = s[b];
      s = t;
      if (is128) begin
        k = {k[66:0], k[127:67]};
        k[127:124] = SB[k[127:124]];
        k[123:120] = SB[k[123:120]];
        k[66:62] = k[66:62] ^ 5'(r);
      end else begin
        k80 = {k80[18:0], k80[79:19]};
        k80[79:76] = SB[k80[79:76]];
        k80[19:15] = k80[19:15] ^ 5'(r);
      end
    end
    return s;
  endfunction

  task automatic send_job(input logic [63:0] pt, input logic [79:0] key,
                          output logic [63:0] ct, output int lat);
    int guard;
    lat   = -1;
    ct    = '0;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    in_pt    = pt;
    in_key   = key;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = c;
        ct  = out_ct;
        break;
      end
    end
  endtask

  task automatic drain;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_ct !== 64'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got valid=%b busy=%b ct=%h want 0 0 0", out_valid, busy, out_ct);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_kat80;
    logic [63:0] pts  [4] = '{64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    logic [79:0] keys [4] = '{80'h0, {80{1'b1}}, 80'h0, {80{1'b1}}};
    logic [63:0] exps [4] = '{64'h5579C1387B228445, 64'hE72C46C0F5945049,
                              64'hA112FFC72F68417B, 64'h3333DCD3213210D2};
    logic [63:0] ct;
    int lat;
    for (int i = 0; i < 4; i++) begin
      send_job(pts[i], keys[i], ct, lat);
      checks++;
      if (ct !== exps[i]) begin
        errors++;
        $display("[TB] FAIL kat80_%0d ct got %h want %h", i, ct, exps[i]);
      end
      checks++;
      if (lat != 32) begin
        errors++;
        $display("[TB] FAIL kat80_%0d latency got %0d want 32", i, lat);
      end
      drain();
    end
  endtask

  task automatic test_kat128_unroll;
    int          lats [6];
    logic [63:0] cts  [6];
    logic [63:0] exp_ct;
    for (int j = 0; j < 2; j++) begin
      if (j == 0) begin
        pt128  = '0;
        key128 = '0;
        exp_ct = 64'h96DB702A2E6900AF;
      end else begin
        pt128  = {$urandom, $urandom};
        key128 = {$urandom, $urandom, $urandom, $urandom};
        exp_ct = ref_enc(pt128, key128, 1'b1);
      end
      for (int g = 0; g < 6; g++) begin
        lats[g] = -1;
        cts[g]  = '0;
      end
      v128 = 1'b1;
      @(negedge clk);
      v128 = 1'b0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        for (int g = 0; g < 6; g++) begin
          if (lats[g] < 0 && ov128[g] === 1'b1) begin
            lats[g] = c;
            cts[g]  = ct128[g];
          end
        end
      end
      for (int g = 0; g < 6; g++) begin
        checks++;
        if (lats[g] != (32 >> g)) begin
          errors++;
          $display("[TB] FAIL k128_u%0d_job%0d latency got %0d want %0d", 1 << g, j, lats[g], 32 >> g);
        end
        checks++;
        if (cts[g] !== exp_ct) begin
          errors++;
          $display("[TB] FAIL k128_u%0d_job%0d ct got %h want %h", 1 << g, j, cts[g], exp_ct);
        end
      end
      r128 = 1'b1;
      @(negedge clk);
      r128 = 1'b0;
      for (int g = 0; g < 6; g++) begin
        checks++;
        if (ir128[g] !== 1'b1 || ov128[g] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL k128_u%0d_release got ready=%b valid=%b want 1 0", 1 << g, ir128[g], ov128[g]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] p1;
    logic [63:0] p2;
    logic [79:0] k1;
    logic [79:0] k2;
    logic [63:0] e1;
    logic [63:0] e2;
    logic [63:0] ct;
    int lat;
    p1 = {$urandom, $urandom};
    k1 = {16'($urandom), $urandom, $urandom};
    p2 = {$urandom, $urandom};
    k2 = {16'($urandom), $urandom, $urandom};
    e1 = ref_enc(p1, {48'h0, k1}, 1'b0);
    e2 = ref_enc(p2, {48'h0, k2}, 1'b0);
    send_job(p1, k1, ct, lat);
    checks++;
    if (ct !== e1) begin
      errors++;
      $display("[TB] FAIL bp_first ct got %h want %h", ct, e1);
    end
    in_pt    = p2;
    in_key   = k2;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_ct !== e1 || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold_%0d got valid=%b ct=%h ready=%b want 1 %h 0", i, out_valid, out_ct, in_ready, e1);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release got valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_accept got busy=%b ready=%b want 1 0", busy, in_ready);
    end
    lat = -1;
    ct  = '0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = c;
        ct  = out_ct;
        break;
      end
    end
    checks++;
    if (lat != 32 || ct !== e2) begin
      errors++;
      $display("[TB] FAIL bp_second got lat=%0d ct=%h want 32 %h", lat, ct, e2);
    end
    drain();
  endtask

  task automatic test_abort;
    logic [63:0] ct;
    int lat;
    in_pt    = {$urandom, $urandom};
    in_key   = {16'($urandom), $urandom, $urandom};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (16) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_pre busy got %b want 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_ct !== 64'h0) begin
      errors++;
      $display("[TB] FAIL abort_async got valid=%b busy=%b ct=%h want 0 0 0", out_valid, busy, out_ct);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_idle got ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    send_job(64'h0, 80'h0, ct, lat);
    checks++;
    if (ct !== 64'h5579C1387B228445 || lat != 32) begin
      errors++;
      $display("[TB] FAIL abort_rerun got ct=%h lat=%0d want 5579c1387b228445 32", ct, lat);
    end
    drain();
  endtask

  task automatic test_random_sweep;
    logic [63:0] expq [$];
    int consumed;
    int budget;
    consumed = 0;
    fork
      begin
        for (int n = 0; n < NJOBS; n++) begin
          int idle;
          int w;
          logic [63:0] p;
          logic [79:0] k;
          idle = $urandom_range(0, 3);
          repeat (idle) @(negedge clk);
          p = {$urandom, $urandom};
          k = {16'($urandom), $urandom, $urandom};
          in_pt    = p;
          in_key   = k;
          in_valid = 1'b1;
          w = 0;
          while (in_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
          end
          if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL sweep_accept_timeout job %0d got ready=%b want 1", n, in_ready);
            in_valid = 1'b0;
            break;
          end
          expq.push_back(ref_enc(p, {48'h0, k}, 1'b0));
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      begin
        budget = 0;
        while (consumed < NJOBS && budget < 60000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid === 1'b1 && out_ready) begin
            checks++;
            if (expq.size() == 0) begin
              errors++;
              $display("[TB] FAIL sweep_spurious got ct=%h want no output", out_ct);
            end else begin
              logic [63:0] e;
              e = expq.pop_front();
              if (out_ct !== e) begin
                errors++;
                $display("[TB] FAIL sweep_ct job %0d got %h want %h", consumed, out_ct, e);
              end
            end
            consumed++;
          end
          @(negedge clk);
          budget++;
        end
        out_ready = 1'b0;
      end
    join
    checks++;
    if (consumed != NJOBS || expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL sweep_count got consumed=%0d pending=%0d want %0d 0", consumed, expq.size(), NJOBS);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_pt     = '0;
    in_key    = '0;
    v128      = 1'b0;
    r128      = 1'b0;
    pt128     = '0;
    key128    = '0;
    #1 rst_n = 1'b0;
    test_reset();
    test_kat80();
    test_kat128_unroll();
    test_backpressure();
    test_abort();
    test_random_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
